se_tone_mixer: RTL and testbench

- Downstream consumer of the sound-effect sequencers (jump, coin, hit, …); each sequencer drives an enable and a 16-bit frequency in Hz.
- Arbitrates up to four sound-effect channels by fixed priority and synthesises a square wave at the winning channel's frequency.
- Uses a fractional-N divider, so no hardware division is needed.
- Drives a 1-bit speaker pin and a signed PCM sample for the audio DAC path.

---
 rtl/se_tone_mixer_if.sv | 21 ++
 rtl/se_tone_mixer.sv | 151 +++++++++++++++
 tb/tb_se_tone_mixer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/se_tone_mixer_if.sv
// Bus between the sound-effect sequencers and the tone mixer: per-channel
// requests in, speaker/PCM outputs back.
interface se_tone_mixer_if;
  logic [3:0]  iEn;
  logic [63:0] iFreq;
  logic        iMute;
  logic        oSquare;
  logic [15:0] oSample;
  logic        oActive;
  logic [1:0]  oChannel;

  modport master (
    output iEn, iFreq, iMute,
    input  oSquare, oSample, oActive, oChannel
  );

  modport slave (
    input  iEn, iFreq, iMute,
    output oSquare, oSample, oActive, oChannel
  );
endinterface

// File: rtl/se_tone_mixer.sv
// Four-channel fixed-priority tone mixer: a registered arbiter feeds a
// fractional-N square-wave generator driving a speaker pin and a PCM sample.
module se_tone_mixer #(
  parameter int CLK_HZ    = 50000000,
  parameter int MAX_FREQ  = 20000,
  parameter int AMPLITUDE = 8192
) (
  input  logic            iClock,
  input  logic            iReset,
  se_tone_mixer_if.slave  bus
);

  localparam logic [31:0] CLK_W    = 32'(CLK_HZ);
  localparam logic [16:0] MAX_W    = 17'(MAX_FREQ);
  localparam logic [15:0] AMP_POS  = 16'(AMPLITUDE);
  localparam logic [15:0] AMP_NEG  = 16'(-AMPLITUDE);

  // Stage 1: per-channel validity and lowest-index winner
  logic [15:0] freq_ch [4];
  logic [3:0]  valid;

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    assign freq_ch[gi] = bus.iFreq[16*gi +: 16];
    assign valid[gi]   = bus.iEn[gi] && (freq_ch[gi] != 16'd0) &&
                         ({1'b0, freq_ch[gi]} < MAX_W);
  end

  logic        win_valid;
  logic [1:0]  win_ch;
  logic [15:0] win_freq;

  always_comb begin
    win_valid = |valid;
    win_ch    = 2'd0;
    win_freq  = 16'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid[i]) begin
        win_ch   = 2'(i);
        win_freq = freq_ch[i];
      end
    end
  end

  logic        sel_valid_reg;
  logic [1:0]  sel_ch_reg;
  logic [15:0] sel_freq_reg;
  logic        prev_valid_reg;
  logic [1:0]  prev_ch_reg;
  logic [15:0] prev_freq_reg;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      sel_valid_reg  <= 1'b0;
      sel_ch_reg     <= 2'd0;
      sel_freq_reg   <= 16'd0;
      prev_valid_reg <= 1'b0;
      prev_ch_reg    <= 2'd0;
      prev_freq_reg  <= 16'd0;
    end else begin
      sel_valid_reg  <= win_valid;
      sel_ch_reg     <= win_ch;
      sel_freq_reg   <= win_freq;
      prev_valid_reg <= sel_valid_reg;
      prev_ch_reg    <= sel_ch_reg;
      prev_freq_reg  <= sel_freq_reg;
    end
  end

  // Stage 2: phase accumulator advancing by 2*freq per clock, modulo CLK_HZ
  logic [31:0] acc_reg, acc_next;
  logic        phase_reg, phase_next;
  logic        active_reg, active_next;
  logic [1:0]  ch_reg, ch_next;
  logic [31:0] sum;
  logic        changed;

  always_comb begin
    acc_next    = acc_reg;
    phase_next  = phase_reg;
    active_next = active_reg;
    ch_next     = ch_reg;
    sum         = acc_reg + {15'd0, sel_freq_reg, 1'b0};
    changed     = !prev_valid_reg || (sel_ch_reg != prev_ch_reg) ||
                  (sel_freq_reg != prev_freq_reg);
    if (!sel_valid_reg) begin
      acc_next    = 32'd0;
      phase_next  = 1'b0;
      active_next = 1'b0;
    end else if (changed) begin
      acc_next    = 32'd0;
      phase_next  = 1'b1;
      active_next = 1'b1;
      ch_next     = sel_ch_reg;
    end else if (sum >= CLK_W) begin
      acc_next    = sum - CLK_W;
      phase_next  = !phase_reg;
    end else begin
      acc_next    = sum;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      acc_reg    <= 32'd0;
      phase_reg  <= 1'b0;
      active_reg <= 1'b0;
      ch_reg     <= 2'd0;
    end else begin
      acc_reg    <= acc_next;
      phase_reg  <= phase_next;
      active_reg <= active_next;
      ch_reg     <= ch_next;
    end
  end

  // Output registers: mute gates only what leaves the block
  logic        square_reg, square_next;
  logic [15:0] sample_reg, sample_next;
  logic        active_out_reg;
  logic [1:0]  channel_out_reg;
  logic        audible;

  always_comb begin
    audible     = active_reg && !bus.iMute;
    square_next = audible && phase_reg;
    sample_next = 16'd0;
    if (audible) begin
      sample_next = phase_reg ? AMP_POS : AMP_NEG;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      square_reg      <= 1'b0;
      sample_reg      <= 16'd0;
      active_out_reg  <= 1'b0;
      channel_out_reg <= 2'd0;
    end else begin
      square_reg      <= square_next;
      sample_reg      <= sample_next;
      active_out_reg  <= active_reg;
      channel_out_reg <= ch_reg;
    end
  end

  assign bus.oSquare  = square_reg;
  assign bus.oSample  = sample_reg;
  assign bus.oActive  = active_out_reg;
  assign bus.oChannel = channel_out_reg;

endmodule

// File: tb/tb_se_tone_mixer.sv
// Directed bench for se_tone_mixer at CLK_HZ=1000 so waveform periods are short.
module tb_se_tone_mixer;
  logic iClock = 1'b0;
  logic iReset = 1'b1;
  int   check_count = 0;
  int   fail_count  = 0;

  se_tone_mixer_if bus ();

  se_tone_mixer #(
    .CLK_HZ   (1000),
    .MAX_FREQ (20000),
    .AMPLITUDE(8192)
  ) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClock = ~iClock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic check_out(input string tag, input logic act, input logic [1:0] ch,
                           input logic sq, input logic [15:0] smp);
    check_val({tag, ".active"},  {31'd0, bus.oActive},  {31'd0, act});
    check_val({tag, ".channel"}, {30'd0, bus.oChannel}, {30'd0, ch});
    check_val({tag, ".square"},  {31'd0, bus.oSquare},  {31'd0, sq});
    check_val({tag, ".sample"},  {16'd0, bus.oSample},  {16'd0, smp});
  endtask

  localparam logic [15:0] POS = 16'h2000;
  localparam logic [15:0] NEG = 16'hE000;

  initial begin
    int highs, rises, toggles, first_low, next_high, next_low;
    logic prev;
    bus.iEn   = 4'b0000;
    bus.iFreq = 64'd0;
    bus.iMute = 1'b0;

    // 1: reset state, then ch0 at 100 Hz -> 5 high / 5 low
    step(2);
    check_out("reset", 1'b0, 2'd0, 1'b0, 16'd0);
    iReset = 1'b0;
    bus.iEn = 4'b0001;
    bus.iFreq[15:0] = 16'd100;
    step(2);
    check_val("t1.active_k1", {31'd0, bus.oActive}, 32'd0);
    step(1);
    check_out("t1.start", 1'b1, 2'd0, 1'b1, POS);
    highs = 0; rises = 0; prev = 1'b0; first_low = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.oSquare) highs++;
      if (bus.oSquare && !prev) rises++;
      if (!bus.oSquare && first_low < 0) first_low = i;
      if (i == 5) check_val("t1.sample_low", {16'd0, bus.oSample}, {16'd0, NEG});
      prev = bus.oSquare;
      step(1);
    end
    check_val("t1.highs", 32'(highs), 32'd50);
    check_val("t1.periods", 32'(rises), 32'd10);
    check_val("t1.half", 32'(first_low), 32'd5);

    // 2: new note on ch0 at 30 Hz restarts; halves 17/17/16, no drift at 1000 cycles
    bus.iFreq[15:0] = 16'd30;
    step(3);
    check_val("t2.restart", {31'd0, bus.oSquare}, 32'd1);
    toggles = 0; prev = bus.oSquare; first_low = -1; next_high = -1; next_low = -1;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0 && bus.oSquare != prev) begin
        toggles++;
        if (first_low < 0) first_low = i;
        else if (next_high < 0) next_high = i;
        else if (next_low < 0) next_low = i;
      end
      if (i == 999) check_val("t2.last_low", {31'd0, bus.oSquare}, 32'd0);
      prev = bus.oSquare;
      step(1);
    end
    check_val("t2.wrap_high", {31'd0, bus.oSquare}, 32'd1);
    check_val("t2.toggles", 32'(toggles), 32'd59);
    check_val("t2.half1", 32'(first_low), 32'd17);
    check_val("t2.half2", 32'(next_high), 32'd34);
    check_val("t2.half3", 32'(next_low), 32'd50);

    // 3: ch2 plays, ch0 preempts mid low-half, then releases back to ch2
    bus.iEn = 4'b0100;
    bus.iFreq = 64'd0;
    bus.iFreq[47:32] = 16'd100;
    step(3);
    check_out("t3.ch2", 1'b1, 2'd2, 1'b1, POS);
    step(6);
    check_val("t3.ch2_low", {31'd0, bus.oSquare}, 32'd0);
    bus.iEn = 4'b0101;
    bus.iFreq[15:0] = 16'd50;
    step(2);
    check_val("t3.k1_chan", {30'd0, bus.oChannel}, 32'd2);
    step(1);
    check_out("t3.preempt", 1'b1, 2'd0, 1'b1, POS);
    step(9);
    check_val("t3.ch0_high9", {31'd0, bus.oSquare}, 32'd1);
    step(1);
    check_val("t3.ch0_low10", {31'd0, bus.oSquare}, 32'd0);
    bus.iEn = 4'b0100;
    step(3);
    check_out("t3.back_ch2", 1'b1, 2'd2, 1'b1, POS);
    step(5);
    check_val("t3.ch2_half", {31'd0, bus.oSquare}, 32'd0);

    // 4: invalid higher-priority frequencies do not block ch1
    bus.iEn = 4'b0011;
    bus.iFreq = 64'd0;
    bus.iFreq[31:16] = 16'd100;
    step(3);
    check_out("t4.f0_zero", 1'b1, 2'd1, 1'b1, POS);
    bus.iFreq[15:0] = 16'd20000;
    step(3);
    check_val("t4.f0_max", {30'd0, bus.oChannel}, 32'd1);
    bus.iFreq[15:0] = 16'd19999;
    step(3);
    check_val("t4.f0_max_m1", {30'd0, bus.oChannel}, 32'd0);
    bus.iFreq = 64'd0;
    step(3);
    check_out("t4.all_invalid", 1'b0, 2'd0, 1'b0, 16'd0);

    // 5: mute on ch1 silences outputs but the phase keeps running
    bus.iEn = 4'b0010;
    bus.iFreq[31:16] = 16'd100;
    step(3);
    check_out("t5.start", 1'b1, 2'd1, 1'b1, POS);
    step(2);
    bus.iMute = 1'b1;
    step(1);
    check_out("t5.muted", 1'b1, 2'd1, 1'b0, 16'd0);
    step(4);
    bus.iMute = 1'b0;
    step(1);
    check_out("t5.resume_low", 1'b1, 2'd1, 1'b0, NEG);
    step(2);
    check_out("t5.resume_high", 1'b1, 2'd1, 1'b1, POS);

    // 6: reset mid-tone, then release with ch1 still enabled
    step(2);
    iReset = 1'b1;
    step(1);
    check_out("t6.reset", 1'b0, 2'd0, 1'b0, 16'd0);
    step(1);
    iReset = 1'b0;
    step(2);
    check_val("t6.k1_active", {31'd0, bus.oActive}, 32'd0);
    step(1);
    check_out("t6.restart", 1'b1, 2'd1, 1'b1, POS);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end
endmodule
